// File: rtl/snes_tap_pkg.sv
// Shared types and defaults for the SNES vector-fetch tap.
package snes_tap_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_GOT_LO = 1'b1
   } tap_state_e;

   localparam logic VEC_ID_RESET = 1'b0;
   localparam logic VEC_ID_NMI   = 1'b1;

   localparam logic [7:0]  DEF_RST_LO_ADDR = 8'hFC;
   localparam logic [7:0]  DEF_NMI_LO_ADDR = 8'hEA;
   localparam int unsigned DEF_TIMEOUT_CYC = 64;
   localparam int unsigned DEF_CNT_W       = 8;

   // High byte of a vector lives at lo+1 within the same 8-bit page, so $FF pairs with $00.
   function automatic logic [7:0] next_addr(input logic [7:0] a);
      return a + 8'd1;
   endfunction

endpackage

// File: rtl/snes_sat_counter.sv
// Saturating up-counter: increments on inc_i, holds at all-ones, synchronous clear.
module snes_sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         clear_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: step only while below the ceiling.
   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register; clear dominates.
   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/snes_vector_tap.sv
// Watches qualified SNES bus events for a two-byte vector fetch (lo, then lo+1),
// assembles the 16-bit vector, and offers it to hook logic over valid/ready.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a low-byte fetch at the RESET or NMI address
// ST_GOT_LO | low byte held; expecting the matching high byte or timeout
module snes_vector_tap
   import snes_tap_pkg::*;
#(
   parameter logic [7:0]  RST_LO_ADDR = DEF_RST_LO_ADDR,
   parameter logic [7:0]  NMI_LO_ADDR = DEF_NMI_LO_ADDR,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       PA_sync,
   input  logic [7:0]       D_sync,
   input  logic             event_latch,
   output logic             vec_valid,
   input  logic             vec_ready,
   output logic             vec_id,
   output logic [15:0]      vec_addr,
   output logic             overflow,
   input  logic             clr_overflow,
   output logic [CNT_W-1:0] reset_count,
   output logic [CNT_W-1:0] nmi_count
);

   localparam int unsigned     TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   logic             ev_q;
   logic             ev;
   tap_state_e       state_q, state_d;
   logic [7:0]       lo_q, lo_d;
   logic             id_q, id_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   logic             vec_valid_q, vec_valid_d;
   logic             vec_id_q, vec_id_d;
   logic [15:0]      vec_addr_q, vec_addr_d;
   logic             overflow_q, overflow_d;

   logic             lo_hit;
   logic             lo_hit_id;
   logic             hi_match;
   logic             complete;
   logic             slot_free;

   // The level from the synchroniser stays high for many clocks; act only on its first cycle.
   assign ev = event_latch & ~ev_q;

   // Classify the current address as a vector low byte, and check for the expected high byte.
   always_comb begin
      lo_hit    = 1'b0;
      lo_hit_id = VEC_ID_RESET;
      if (PA_sync == RST_LO_ADDR) begin
         lo_hit = 1'b1;
      end else if (PA_sync == NMI_LO_ADDR) begin
         lo_hit    = 1'b1;
         lo_hit_id = VEC_ID_NMI;
      end
   end

   assign hi_match = (PA_sync == next_addr((id_q == VEC_ID_NMI) ? NMI_LO_ADDR : RST_LO_ADDR));

   // Fetch-tracking FSM next state; a mismatched event in GOT_LO is re-judged as a fresh low byte.
   always_comb begin
      state_d  = state_q;
      lo_d     = lo_q;
      id_d     = id_q;
      tmo_d    = tmo_q;
      complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ev && lo_hit) begin
               state_d = ST_GOT_LO;
               lo_d    = D_sync;
               id_d    = lo_hit_id;
               tmo_d   = '0;
            end
         end
         ST_GOT_LO: begin
            if (ev) begin
               if (hi_match) begin
                  complete = 1'b1;
                  state_d  = ST_IDLE;
               end else if (lo_hit) begin
                  state_d = ST_GOT_LO;
                  lo_d    = D_sync;
                  id_d    = lo_hit_id;
                  tmo_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output slot: a completed vector lands only if the slot is empty or being drained this cycle.
   always_comb begin
      slot_free   = ~vec_valid_q | vec_ready;
      vec_valid_d = vec_valid_q & ~vec_ready;
      vec_id_d    = vec_id_q;
      vec_addr_d  = vec_addr_q;
      overflow_d  = overflow_q;
      if (clr_overflow) begin
         overflow_d = 1'b0;
      end
      if (complete) begin
         if (slot_free) begin
            vec_valid_d = 1'b1;
            vec_id_d    = id_q;
            vec_addr_d  = {D_sync, lo_q};
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   // State, capture and slot registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ev_q        <= 1'b0;
         state_q     <= ST_IDLE;
         lo_q        <= '0;
         id_q        <= VEC_ID_RESET;
         tmo_q       <= '0;
         vec_valid_q <= 1'b0;
         vec_id_q    <= 1'b0;
         vec_addr_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         ev_q        <= event_latch;
         state_q     <= state_d;
         lo_q        <= lo_d;
         id_q        <= id_d;
         tmo_q       <= tmo_d;
         vec_valid_q <= vec_valid_d;
         vec_id_q    <= vec_id_d;
         vec_addr_q  <= vec_addr_d;
         overflow_q  <= overflow_d;
      end
   end

   // Completions are counted even when the vector itself is dropped.
   snes_sat_counter #(.W(CNT_W)) u_reset_cnt (
      .clk_i   (clk),
      .clear_i (~rst_n),
      .inc_i   (complete && (id_q == VEC_ID_RESET)),
      .count_o (reset_count)
   );

   snes_sat_counter #(.W(CNT_W)) u_nmi_cnt (
      .clk_i   (clk),
      .clear_i (~rst_n),
      .inc_i   (complete && (id_q == VEC_ID_NMI)),
      .count_o (nmi_count)
   );

   assign vec_valid = vec_valid_q;
   assign vec_id    = vec_id_q;
   assign vec_addr  = vec_addr_q;
   assign overflow  = overflow_q;

endmodule
